// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: synchronizes the pins, deframes start/8 data/odd parity/stop,
// and presents good bytes through a one-deep valid/ready output register.
module ps2_rx_ctrl #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_ready,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   prev_clk;
    logic                   sync_clk, sample, fall;
    logic [2:0]             bitcnt, bitcnt_n;
    logic                   parity, parity_n;
    logic [7:0]             shreg, shreg_n, rev;
    logic [TW-1:0]          tcnt, tcnt_n;
    logic                   perr_n, ferr_n, deliver_n, deliver_q;

    assign sync_clk = clk_sync[SYNC_STAGES-1];
    assign sample   = data_sync[SYNC_STAGES-1];
    assign fall     = prev_clk & ~sync_clk;
    assign busy     = (state != IDLE);

    // Synchronizers and edge flop reset high to match the idle bus, so reset release is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            prev_clk  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample pre-edge values, forming a true shift chain.
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            prev_clk  <= sync_clk;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bitcnt     <= '0;
            parity     <= 1'b0;
            shreg      <= '0;
            tcnt       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            deliver_q  <= 1'b0;
        end else begin
            state      <= state_n;
            bitcnt     <= bitcnt_n;
            parity     <= parity_n;
            shreg      <= shreg_n;
            tcnt       <= tcnt_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
            deliver_q  <= deliver_n;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_n   = state;
        bitcnt_n  = bitcnt;
        parity_n  = parity;
        shreg_n   = shreg;
        tcnt_n    = (fall || state == IDLE) ? '0 : tcnt + 1'b1;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        deliver_n = 1'b0;

        case (state)
            IDLE: if (fall && !sample) begin
                state_n  = DATA;
                bitcnt_n = '0;
                parity_n = 1'b0;
            end
            DATA: if (fall) begin
                shreg_n  = {shreg[6:0], sample};
                parity_n = parity ^ sample;
                bitcnt_n = bitcnt + 1'b1;
                if (bitcnt == 3'd7) state_n = PAR;
            end
            PAR: if (fall) begin
                parity_n = parity ^ sample;
                state_n  = STOP;
            end
            STOP: if (fall) begin
                state_n = IDLE;
                if (!sample)      ferr_n    = 1'b1;
                else if (!parity) perr_n    = 1'b1;
                else              deliver_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // A stalled bus mid-frame abandons the partial byte.
        if (state != IDLE && !fall && tcnt == TMAX) begin
            state_n = IDLE;
            ferr_n  = 1'b1;
        end
    end

    // First wire bit lands in shreg[7] after eight left shifts.
    always_comb begin
        rev = '0;
        for (int i = 0; i < 8; i++) rev[i] = shreg[7-i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code       <= '0;
            code_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver_q) begin
                if (!code_valid || rd_ready) begin
                    code       <= rev;
                    code_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (code_valid && rd_ready) begin
                code_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl: bit-banged PS/2 frames with hand-computed expected codes
// and error-pulse counts.
module tb_ps2_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_ready = 1'b0;
    logic [7:0] code;
    logic       code_valid, parity_err, frame_err, overrun, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int pe_cnt = 0, fe_cnt = 0, ov_cnt = 0;
    int pe0, fe0, ov0;

    ps2_rx_ctrl #(.TIMEOUT_CYC(100), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_ready(rd_ready), .code(code), .code_valid(code_valid),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse so a stretched pulse shows up as a count above one.
    always @(negedge clk) begin
        if (parity_err) pe_cnt++;
        if (frame_err)  fe_cnt++;
        if (overrun)    ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        pe0 = pe_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    endtask

    task automatic check_pulses(input string tag, input int pe, input int fe, input int ov);
        check({tag, "_parity_err"}, pe_cnt - pe0, pe);
        check({tag, "_frame_err"},  fe_cnt - fe0, fe);
        check({tag, "_overrun"},    ov_cnt - ov0, ov);
    endtask

    // One wire bit: data set while ps2_clk is high, then a 20-cycle low phase.
    task automatic send_bit(input logic b, input bit rd_pulse, input bit chk_lat, input logic cv_old);
        ps2_data = b;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        if (chk_lat) check("lat_before", code_valid, cv_old);
        if (rd_pulse) rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        if (chk_lat) check("lat_after", code_valid, 1'b1);
        repeat (16) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input bit rd_pulse, input bit chk_lat);
        logic cv_old;
        cv_old = code_valid;
        send_bit(1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 0, 0, 1'b0);
        send_bit(par, 0, 0, 1'b0);
        send_bit(stop, rd_pulse, chk_lat, cv_old);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic read_pulse();
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d1c, d5a, df0;
        d1c = 8'h1C; d5a = 8'h5A; df0 = 8'hF0;

        repeat (3) @(negedge clk);
        check("rst_code", code, 8'h00);
        check("rst_valid", code_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_errs", {parity_err, frame_err, overrun}, 3'b000);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // 1: clean 0x1C (three ones -> parity bit 0), checks delivery latency, then read.
        snap();
        send_frame(d1c, 1'b0, 1'b1, 0, 1);
        check("t1_code", code, 8'h1C);
        check("t1_valid", code_valid, 1'b1);
        repeat (30) @(negedge clk);
        check("t1_valid_held", code_valid, 1'b1);
        read_pulse();
        check("t1_valid_read", code_valid, 1'b0);
        check("t1_code_kept", code, 8'h1C);
        check_pulses("t1", 0, 0, 0);

        // 2: 0xF0 needs parity 1; send 0.
        snap();
        send_frame(df0, 1'b0, 1'b1, 0, 0);
        check("t2_valid", code_valid, 1'b0);
        check("t2_busy", busy, 1'b0);
        check("t2_code", code, 8'h1C);
        check_pulses("t2", 1, 0, 0);

        // 3: 0x5A with correct parity 1 but stop bit 0.
        snap();
        send_frame(d5a, 1'b1, 1'b0, 0, 0);
        check("t3_valid", code_valid, 1'b0);
        check_pulses("t3", 0, 1, 0);

        // 4: start plus four data bits, then the bus stalls past the timeout.
        snap();
        send_bit(1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(d5a[i], 0, 0, 1'b0);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        check("t4_busy_mid", busy, 1'b1);
        check_pulses("t4_mid", 0, 0, 0);
        repeat (100) @(negedge clk);
        check("t4_busy_after", busy, 1'b0);
        check_pulses("t4", 0, 1, 0);
        snap();
        send_frame(d1c, 1'b0, 1'b1, 0, 0);
        check("t4_code", code, 8'h1C);
        check("t4_valid", code_valid, 1'b1);
        check_pulses("t4_clean", 0, 0, 0);

        // 5: output register full -> overrun; then a read in the delivery cycle.
        read_pulse();
        snap();
        send_frame(d1c, 1'b0, 1'b1, 0, 0);
        send_frame(d5a, 1'b1, 1'b1, 0, 0);
        check("t5_code_kept", code, 8'h1C);
        check("t5_valid", code_valid, 1'b1);
        check_pulses("t5_ovr", 0, 0, 1);
        snap();
        send_frame(d5a, 1'b1, 1'b1, 1, 0);
        check("t5_code_new", code, 8'h5A);
        check("t5_valid_new", code_valid, 1'b1);
        check_pulses("t5_rd", 0, 0, 0);

        // 6: reset mid-frame with a byte still held.
        send_bit(1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(d1c[i], 0, 0, 1'b0);
        repeat (5) @(negedge clk);
        check("t6_busy_pre", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t6_code", code, 8'h00);
        check("t6_valid", code_valid, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_errs", {parity_err, frame_err, overrun}, 3'b000);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        snap();
        send_frame(d1c, 1'b0, 1'b1, 0, 1);
        check("t6_code_after", code, 8'h1C);
        check("t6_valid_after", code_valid, 1'b1);
        check_pulses("t6", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
